dmem_lsu: RTL and testbench

- Load/store unit; the initiator side of the data-memory port.
- Accepts one CPU load/store request at a time over a valid/ready handshake, converts byte addresses to word addresses and drives the 16-bit word-wide data memory.
- Handles the memory's 1-cycle registered read latency and implements byte stores as read-modify-write, since the memory has no byte enables.
- Sits between the execute stage and the data memory; shares the memory's clk_en speed control.

---
 rtl/dmem_lsu.sv | 177 +++++++++++++++++
 tb/tb_dmem_lsu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit driving a 16-bit word-wide data memory with 1-cycle registered reads.
// Byte stores are read-modify-write. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned word accesses.
module dmem_lsu #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH:0]   req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  resp_valid,
    output logic [15:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [15:0]           mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WRITE,
        S_TRAP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  r_write;
    logic                  r_byte;
    logic                  r_signed;
    logic                  r_lane;
    logic [7:0]            r_wbyte;
    logic                  r_resp_valid;
    logic [15:0]           r_resp_rdata;
    logic                  r_resp_err;
    logic [ADDR_WIDTH-1:0] r_mem_raddr;
    logic [ADDR_WIDTH-1:0] r_mem_waddr;
    logic [15:0]           r_mem_wdata;
    logic                  r_mem_we;

    logic                  w_accept;
    logic                  w_misalign;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [7:0]            w_lane_byte;
    logic [15:0]           w_load_data;
    logic [15:0]           w_merge_data;

    assign w_word_addr = req_addr[ADDR_WIDTH:1];

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = !req_byte && req_addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign)                  w_next = S_TRAP;
                    else if (req_write && !req_byte) w_next = S_WRITE;
                    else                             w_next = S_RD;
                end
            end
            S_RD:    w_next = S_RDW;
            S_RDW:   w_next = r_write ? S_WRITE : S_IDLE;
            S_WRITE: w_next = S_IDLE;
            S_TRAP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        req_ready = (r_state == S_IDLE);
        w_accept  = req_valid && req_ready;
    end

    // Lane select, load formatting and byte-store merge on the returning memory word
    always_comb begin
        w_lane_byte = r_lane ? mem_rdata[15:8] : mem_rdata[7:0];
        if (!r_byte)       w_load_data = mem_rdata;
        else if (r_signed) w_load_data = {{8{w_lane_byte[7]}}, w_lane_byte};
        else               w_load_data = {8'h00, w_lane_byte};
        w_merge_data = r_lane ? {r_wbyte, mem_rdata[7:0]} : {mem_rdata[15:8], r_wbyte};
    end

    // Registered datapath and memory-side outputs
    always_ff @(posedge clk) begin
        // NOTE: request capture registers are reset too, keeping the block fully deterministic after rst.
        if (rst) begin
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
            r_signed     <= 1'b0;
            r_lane       <= 1'b0;
            r_wbyte      <= 8'h00;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 16'h0000;
            r_resp_err   <= 1'b0;
            r_mem_raddr  <= '0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= 16'h0000;
            r_mem_we     <= 1'b0;
        end else if (clk_en) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_byte      <= req_byte;
                        r_signed    <= req_signed;
                        r_lane      <= req_addr[0];
                        r_wbyte     <= req_wdata[7:0];
                        r_mem_raddr <= w_word_addr;
                        r_mem_waddr <= w_word_addr;
                        if (req_write && !req_byte && !w_misalign) begin
                            r_mem_wdata <= req_wdata;
                            r_mem_we    <= 1'b1;
                        end
                    end
                end
                S_RDW: begin
                    if (r_write) begin
                        r_mem_wdata <= w_merge_data;
                        r_mem_we    <= 1'b1;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_resp_rdata <= 16'h0000;
                    r_resp_valid <= 1'b1;
                end
                S_TRAP: begin
                    r_resp_rdata <= 16'h0000;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_raddr  = r_mem_raddr;
    assign mem_waddr  = r_mem_waddr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: behavioural memory, word-level reference model and response monitor.
module tb_dmem_lsu;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst, clk_en, req_valid, req_ready, req_write, req_byte, req_signed;
    logic [AW:0]   req_addr;
    logic [15:0]   req_wdata;
    logic          resp_valid, resp_err, mem_we;
    logic [15:0]   resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_raddr, mem_waddr;

    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [15:0]   pl_data;
    logic [15:0]   mem     [0:(1<<AW)-1];
    logic [15:0]   ref_mem [0:(1<<AW)-1];

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_resp = 0;
    int edge_cnt = 0;
    int acc_edge = 0;
    int wr_cnt = 0;
    bit rand_en = 0;

    dmem_lsu #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: registered read, write on mem_we, both gated by clk_en; preload port for setup
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (clk_en) begin
            if (mem_we) mem[mem_waddr] <= mem_wdata;
            mem_rdata <= mem[mem_raddr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks accepts and enabled edges, pops one expectation per response
    always @(posedge clk) begin
        bit   en_now;
        bit   acc_now;
        exp_t e;
        en_now  = clk_en && !rst;
        acc_now = en_now && req_valid && req_ready;
        if (en_now) edge_cnt++;
        if (acc_now) begin
            acc_edge = edge_cnt;
            wr_cnt   = 0;
        end
        #1;
        if (en_now && mem_we) wr_cnt++;
        if (en_now && resp_valid) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("latency", 32'(edge_cnt - acc_edge + 1), 32'(e.lat));
                check("mem_we_pulses", 32'(wr_cnt), 32'(e.nwr));
            end
        end
    end

    // Reference model: word-array view of memory with little-endian byte lanes
    task automatic model(input logic wr, input logic by, input logic sg,
                         input logic [AW:0] a, input logic [15:0] wd);
        exp_t          e;
        logic [AW-1:0] w;
        logic          lane;
        logic [15:0]   old;
        logic [7:0]    b;
        w    = a[AW:1];
        lane = a[0];
        old  = ref_mem[w];
        e.rdata = 16'h0000;
        e.err   = 1'b0;
        e.nwr   = 0;
        e.lat   = 0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (!by && lane) begin
            e.err = 1'b1;
            e.lat = 2;
            exp_q.push_back(e);
            return;
        end
`endif
        if (wr) begin
            e.nwr = 1;
            if (by) begin
                e.lat = 4;
                ref_mem[w] = lane ? {wd[7:0], old[7:0]} : {old[15:8], wd[7:0]};
            end else begin
                e.lat = 2;
                ref_mem[w] = wd;
            end
        end else begin
            e.lat = 3;
            if (!by) begin
                e.rdata = old;
            end else begin
                b = lane ? old[15:8] : old[7:0];
                e.rdata = sg ? 16'($signed(b)) : {8'h00, b};
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        if (rand_en) clk_en = ($urandom_range(0, 3) != 0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
    endtask

    task automatic issue(input logic wr, input logic by, input logic sg,
                         input logic [AW:0] a, input logic [15:0] wd, input bit push);
        bit fired;
        step();
        req_write  = wr;
        req_byte   = by;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        if (push) model(wr, by, sg, a, wd);
        fired = 0;
        for (int n = 0; n < 200 && !fired; n++) begin
            @(posedge clk);
            if (req_ready && clk_en && !rst) fired = 1;
            else step();
        end
        #1;
        if (!fired) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept of addr %h", a);
        end else begin
            check("mem_raddr", 32'(mem_raddr), 32'(a[AW:1]));
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int            resp_before;
        logic [AW-1:0] w;
        logic [AW:0]   a;
        rst = 1'b1; clk_en = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_byte = 1'b0; req_signed = 1'b0; req_addr = '0; req_wdata = 16'h0000;
        pl_we = 1'b0; pl_addr = '0; pl_data = 16'h0000;

        // Preload the working window while reset is held with clk_en low
        for (int i = 0; i < 8; i++)
            preload(AW'(16'h0010 + i), (i == 0) ? 16'hBEEF : 16'($urandom));
        preload({AW{1'b1}}, 16'($urandom));
        @(negedge clk);
        pl_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clk_en = 1'b1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_raddr", 32'(mem_raddr), 32'd0);
        check("rst_mem_waddr", 32'(mem_waddr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        // Word load, byte-store RMW and reload
        issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1);
        issue(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0012, 1);
        issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1);
        drain();

        // Byte loads of the high lane, signed and unsigned
        issue(1'b1, 1'b0, 1'b0, 16'h0020, 16'h80FF, 1);
        issue(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 1);
        issue(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1);
        issue(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 1);
        drain();

        // Stall a load in RDW for 5 cycles
        issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1);
        @(posedge clk);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_resp_valid", 32'(resp_valid), 32'd0);
        check("stall_req_ready", 32'(req_ready), 32'd0);
        check("stall_mem_raddr", 32'(mem_raddr), 32'h0010);
        check("stall_mem_rdata", 32'(mem_rdata), 32'h80FF);
        clk_en = 1'b1;
        drain();

        // resp_valid holds while clk_en is low
        issue(1'b1, 1'b0, 1'b0, 16'h0024, 16'hA55A, 1);
        @(posedge clk);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_resp_valid", 32'(resp_valid), 32'd1);
        check("hold_resp_rdata", 32'(resp_rdata), 32'd0);
        clk_en = 1'b1;
        drain();

        // Reset during a byte store's RDW aborts it
        resp_before = n_resp;
        issue(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0077, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_write_pulses", 32'(wr_cnt), 32'd0);
        check("abort_responses", 32'(n_resp - resp_before), 32'd0);
        check("abort_mem_word", 32'(mem[15'h0010]), 32'(ref_mem[15'h0010]));

        // Misaligned word store, then reload the aligned word
        issue(1'b1, 1'b0, 1'b0, 16'h0021, 16'h5A5A, 1);
        issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 1);
        drain();

        // Randomized traffic with random clk_en over the window and the top word
        rand_en = 1;
        for (int i = 0; i < 150; i++) begin
            w = ($urandom_range(0, 4) == 0) ? {AW{1'b1}} : AW'(16'h0010 + $urandom_range(0, 7));
            a = {w, 1'($urandom)};
            issue(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), 1);
        end
        drain();
        rand_en = 0;
        clk_en = 1'b1;
        for (int i = 0; i < 8; i++)
            check("final_mem_word", 32'(mem[AW'(16'h0010 + i)]), 32'(ref_mem[AW'(16'h0010 + i)]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
